pipe_hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage RISC-V core. It tracks in-flight register writers through EX/MEM/WB and detects read-after-write hazards at ID. It drives the `ban` input of the ID control decoder to insert bubbles, holds PC and IF/ID on stalls, and squashes wrong-path instructions after a taken branch or jump. It also freezes the whole pipeline while data memory is busy, and keeps saturating stall and flush counters for performance analysis.

---
 rtl/pipe_hazard_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: tracks in-flight register writers, detects RAW
// hazards at ID, squashes wrong-path fetches after redirects, freezes on memory busy.
module pipe_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned FWD          = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  id_rd,
   input  logic        id_regwr,
   input  logic        id_memtoreg,
   input  logic        ex_taken,
   input  logic        mem_busy,
   output logic        pc_hold,
   output logic        ifid_hold,
   output logic        id_ban,
   output logic        ifid_flush,
   output logic        freeze,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_events
);

   localparam int unsigned RW = 5;
   localparam int unsigned CW = 16;
   localparam int unsigned FW = 3;
   localparam logic [CW-1:0] CNT_MAX    = '1;
   localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES - 1);

   typedef struct packed {
      logic          valid;
      logic [RW-1:0] rd;
      logic          regwr;
      logic          memtoreg;
   } ex_slot_t;

   // MEM slot only needs writer identity; WB writers are bypassed by the register file.
   typedef struct packed {
      logic          valid;
      logic [RW-1:0] rd;
      logic          regwr;
   } mem_slot_t;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [FW-1:0] r_fcnt;
   logic [FW-1:0] w_fcnt_nxt;
   ex_slot_t      r_ex;
   mem_slot_t     r_mem;
   ex_slot_t      w_id_slot;
   logic [CW-1:0] r_stall_cycles;
   logic [CW-1:0] r_flush_events;

   logic w_adv;
   logic w_stall_inc;
   logic w_flush_inc;
   logic w_ex_rs1;
   logic w_ex_rs2;
   logic w_mem_rs1;
   logic w_mem_rs2;
   logic w_ex_hit;
   logic w_mem_hit;
   logic w_hazard;

   // Source-match per slot; x0 never matches.
   assign w_ex_rs1  = r_ex.valid  && r_ex.regwr  && (r_ex.rd  == id_rs1) && (id_rs1 != '0);
   assign w_ex_rs2  = r_ex.valid  && r_ex.regwr  && (r_ex.rd  == id_rs2) && (id_rs2 != '0);
   assign w_mem_rs1 = r_mem.valid && r_mem.regwr && (r_mem.rd == id_rs1) && (id_rs1 != '0);
   assign w_mem_rs2 = r_mem.valid && r_mem.regwr && (r_mem.rd == id_rs2) && (id_rs2 != '0);

   assign w_ex_hit  = (id_use_rs1 && w_ex_rs1)  || (id_use_rs2 && w_ex_rs2);
   assign w_mem_hit = (id_use_rs1 && w_mem_rs1) || (id_use_rs2 && w_mem_rs2);

   assign w_hazard = id_valid && ((FWD != 0) ? (w_ex_hit && r_ex.memtoreg)
                                             : (w_ex_hit || w_mem_hit));

   assign w_id_slot = '{valid:    id_valid && !id_ban,
                        rd:       id_rd,
                        regwr:    id_regwr,
                        memtoreg: id_memtoreg};

   // Next-state and control outputs; priority rst > freeze > redirect/flush > hazard.
   always_comb begin
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      id_ban      = 1'b0;
      ifid_flush  = 1'b0;
      freeze      = 1'b0;
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      w_adv       = 1'b0;
      w_stall_inc = 1'b0;
      w_flush_inc = 1'b0;
      if (rst) begin
         id_ban     = 1'b1;
         ifid_flush = 1'b1;
      end else if (mem_busy) begin
         freeze = 1'b1;
      end else begin
         w_adv = 1'b1;
         case (r_state)
            S_RUN: begin
               if (ex_taken) begin
                  id_ban      = 1'b1;
                  ifid_flush  = 1'b1;
                  w_flush_inc = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     w_state_nxt = S_FLUSH;
                     w_fcnt_nxt  = FLUSH_INIT;
                  end
               end else if (w_hazard) begin
                  pc_hold     = 1'b1;
                  ifid_hold   = 1'b1;
                  id_ban      = 1'b1;
                  w_stall_inc = 1'b1;
               end
            end
            S_FLUSH: begin
               id_ban     = 1'b1;
               ifid_flush = 1'b1;
               w_fcnt_nxt = r_fcnt - 1'b1;
               if (r_fcnt <= FW'(1)) begin
                  w_state_nxt = S_RUN;
               end
            end
            default: begin
               w_state_nxt = S_RUN;
            end
         endcase
      end
   end

   // State, shadow slots and saturating counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_RUN;
         r_fcnt         <= '0;
         r_ex           <= '0;
         r_mem          <= '0;
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
         if (w_adv) begin
            r_mem <= '{valid: r_ex.valid, rd: r_ex.rd, regwr: r_ex.regwr};
            r_ex  <= w_id_slot;
         end
         if (w_stall_inc && (r_stall_cycles != CNT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
         end
         if (w_flush_inc && (r_flush_events != CNT_MAX)) begin
            r_flush_events <= r_flush_events + 1'b1;
         end
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;

endmodule
